instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage and IF/ID pipeline register for the 5-stage MIPS core. It issues word fetches to instruction memory over a req/ack handshake and presents `pc_id`, `instr_id` and `valid_id` to the decode stage. It also applies decode's `stall` and redirect outputs (`jump_branch`, `jump_target`, `jump_reg`, `jr_pc`). Redirects follow MIPS branch-delay-slot semantics: the instruction at `pc_id+4` always executes.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset

- `clk` in 1: core clock, all state on rising edge
- `rst_n` in 1: asynchronous active-low reset
- `stall` in 1: decode load-use stall; hold the IF/ID contents
- `jump_branch` in 1: taken conditional branch for the instruction in ID
- `jump_target` in 1: J/JAL for the instruction in ID
- `jump_reg` in 1: JR/JALR for the instruction in ID
- `jr_pc` in 32: forwarded rs value, the JR/JALR target
- `imem_req` out 1: fetch request; held high until acked
- `imem_addr` out 32: fetch word address; stable while `imem_req` is high
- `imem_ack` in 1: fetch complete; `imem_rdata` is valid this cycle
- `imem_rdata` in 32: fetched instruction
- `pc_id` out 32: PC of the instruction in ID
- `instr_id` out 32: instruction in ID (32'h0 = nop when invalid)
- `valid_id` out 1: ID holds a real instruction

## Operation
- **Registers**
  - `req_pc`: next or outstanding fetch address; drives `imem_addr`.
  - Hold buffer (`hold_pc`, `hold_instr`).
  - `pend_valid` / `pend_target`: deferred redirect.
  - IF/ID registers.
  - Two-state FSM: FETCH and HOLD.
- **Accept condition:** `accept = ~stall | ~valid_id`.
- **FETCH state**
  - `imem_req` = 1.
  - On `imem_ack` with `accept`: IF/ID <= {`imem_addr`, `imem_rdata`}, `valid_id` <= 1.
  - On `imem_ack` with `~accept`: hold <= {`imem_addr`, `imem_rdata`}; go to HOLD.
  - On every ack: `req_pc` <= `pend_valid ? pend_target : req_pc+4`, and `pend_valid` is cleared.
  - No ack with `accept`: IF/ID <= bubble (`valid_id`=0, `instr_id`=0, `pc_id` unchanged).
- **HOLD state**
  - `imem_req` = 0.
  - On `accept`: IF/ID <= hold; go to FETCH.
- **stall with `valid_id`=1:** IF/ID holds unchanged. Redirect inputs are ignored.
- **Redirect**
  - A redirect is taken when `valid_id & ~stall & (jump_reg | jump_target | jump_branch)`.
  - Target priority: `jump_reg` > `jump_target` > `jump_branch`.
  - `jump_reg` target: `jr_pc`.
  - `jump_target` target: `{pc_id[31:28]+carry of pc_id+4, instr_id[25:0], 2'b00}`, i.e. the upper 4 bits of `pc_id+4`.
  - `jump_branch` target: `pc_id + 4 + {{14{instr_id[15]}}, instr_id[15:0], 2'b00}`, modulo 2^32.
- **Applying the target**
  - Invariant: at redirect time the delay slot (`pc_id+4`) is either outstanding in FETCH or sitting in the hold buffer.
  - If in FETCH without ack this cycle: `pend_valid` <= 1, `pend_target` <= target.
  - If in FETCH with ack this cycle, or in HOLD: `req_pc` <= target directly; the pend path is not used.
  - The delay slot is never discarded.
- **Redirect while `pend_valid`** (branch in delay slot, ISA-undefined): the newer target overwrites `pend_target`.
- **Ack while `imem_req`=0:** ignored.
- **PC rules:** PCs are byte addresses and always increment by 4. `imem_addr[1:0]` is passed through as-is; no alignment check.

## Timing
- **Reset values**
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `valid_id`=0, `instr_id`=0, `pc_id`=0.
  - `pend_valid`=0; FSM = FETCH.
- `imem_req` rises on the first rising edge after `rst_n` deasserts.
- An assertion of `rst_n` mid-fetch abandons the outstanding request immediately; imem must share `rst_n`.
- **Latency:** ack in cycle N → `valid_id`=1 with that instruction in cycle N+1.
- **Back-to-back acks:** 1 instruction/cycle; `imem_addr` advances the cycle after each ack.
- **HOLD timing:** entered on the cycle after an ack under stall. With stall dropping in cycle M: IF/ID loads hold at M+1 and `imem_req` reasserts at M+1.
- **Redirect timing:**
  - Redirect in cycle R with ack in R: target is requested from R+1.
  - Redirect with ack later at cycle A: target is requested from A+1.

## Test plan
- **Straight line:** `RESET_PC`=0x100, imem acks every cycle with `rdata`=addr → `imem_addr` sequence 0x100, 0x104, 0x108…; `pc_id`/`instr_id` trail by one cycle; `valid_id`=1 from the second cycle after reset release.
- **Taken branch, 3-cycle memory:** `instr_id`=0x1000FFFE at `pc_id`=0x200 with `jump_branch`=1 while 0x204 is outstanding → 0x204 still delivered to ID; next `imem_addr`=0x1FC; `pend_valid` path exercised.
- **J and JR:**
  - `instr_id`=0x08000040 at `pc_id`=0x3000_0010 → delay slot fetched, then `imem_addr`=0x3000_0100.
  - `jump_reg` with `jr_pc`=0xDEAD_BEE0 → next address after the delay slot is 0xDEAD_BEE0.
- **Stall with hold:** stall high for 3 cycles while ack arrives → IF/ID unchanged, `imem_req`=0 in HOLD; on release the held instruction appears in ID the next cycle and fetch resumes at +4 with no duplicate or loss.
- **Stall plus redirect:** `jump_branch`=1 while `stall`=1 → no redirect; the same branch with stall low next cycle → redirect taken once.
- **Reset mid-fetch:** pull `rst_n` low while `imem_req`=1 → outputs go to reset values asynchronously; after release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage with IF/ID pipeline register.
// Word fetches over req/ack; redirects honour the branch delay slot.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        jump_branch,
  input  logic        jump_target,
  input  logic        jump_reg,
  input  logic [31:0] jr_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_id,
  output logic [31:0] instr_id,
  output logic        valid_id
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        run;
  logic [31:0] req_pc;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic        accept;
  logic        ack;
  logic        redir;
  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] target;

  assign imem_req  = run & (state == FETCH);
  assign imem_addr = req_pc;
  assign accept    = ~stall | ~valid_id;
  assign ack       = imem_ack & imem_req;
  assign redir     = valid_id & ~stall &
                     (jump_reg | jump_target | jump_branch);
  assign pc4       = pc_id + 32'd4;
  assign br_off    = {{14{instr_id[15]}},
                      instr_id[15:0], 2'b00};

  // Redirect target, jump_reg wins over J, J wins over branch
  always_comb begin
    target = pc4 + br_off;
    priority case (1'b1)
      jump_reg:    target = jr_pc;
      jump_target: target = {pc4[31:28],
                             instr_id[25:0], 2'b00};
      default:     target = pc4 + br_off;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_nx;
    end
  end

  // Park in HOLD when a fetch lands while ID cannot take it
  always_comb begin
    state_nx = state;
    unique case (state)
      FETCH: if (ack && !accept) state_nx = HOLD;
      HOLD:  if (accept) state_nx = FETCH;
      default: state_nx = FETCH;
    endcase
  end

  // Fetch address, hold buffer, deferred redirect and IF/ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      req_pc      <= RESET_PC;
      hold_pc     <= '0;
      hold_instr  <= '0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      pc_id       <= '0;
      instr_id    <= '0;
      valid_id    <= 1'b0;
    end else begin
      run <= 1'b1;
      if (state == FETCH) begin
        if (ack) begin
          if (accept) begin
            pc_id    <= req_pc;
            instr_id <= imem_rdata;
            valid_id <= 1'b1;
          end else begin
            hold_pc    <= req_pc;
            hold_instr <= imem_rdata;
          end
          if (redir) begin
            req_pc <= target;
          end else if (pend_valid) begin
            req_pc <= pend_target;
          end else begin
            req_pc <= req_pc + 32'd4;
          end
          pend_valid <= 1'b0;
        end else begin
          if (accept) begin
            instr_id <= '0;
            valid_id <= 1'b0;
          end
          if (redir) begin
            pend_valid  <= 1'b1;
            pend_target <= target;
          end
        end
      end else begin
        if (accept) begin
          pc_id    <= hold_pc;
          instr_id <= hold_instr;
          valid_id <= 1'b1;
        end
        if (redir) begin
          req_pc <= target;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: vector table, directed corner
// sequences and a randomized run against a program-order model.
module tb_instruction_fetch;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        jump_branch = 1'b0;
  logic        jump_target = 1'b0;
  logic        jump_reg = 1'b0;
  logic [31:0] jr_pc = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc_id;
  logic [31:0] instr_id;
  logic        valid_id;

  int errs = 0;
  int checks = 0;
  bit hash_mode = 1'b0;

  instruction_fetch #(.RESET_PC(RPC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .jump_branch(jump_branch),
    .jump_target(jump_target),
    .jump_reg(jump_reg),
    .jr_pc(jr_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .pc_id(pc_id),
    .instr_id(instr_id),
    .valid_id(valid_id)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  function automatic logic [31:0] dir_word(input logic [31:0] a);
    case (a)
      32'h0000_0200: return 32'h1000_FFFE;
      32'h3000_0010: return 32'h0800_0040;
      default:       return a;
    endcase
  endfunction

  assign imem_rdata = hash_mode ? hash(imem_addr)
                                : dir_word(imem_addr);

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit st, input bit jb,
                       input bit jt, input bit jr,
                       input logic [31:0] jp, input bit ak);
    stall       = st;
    jump_branch = jb;
    jump_target = jt;
    jump_reg    = jr;
    jr_pc       = jp;
    imem_ack    = ak;
  endtask

  task automatic chk_out(input string t, input logic rq,
                         input logic [31:0] ad, input logic v,
                         input logic [31:0] pc,
                         input logic [31:0] ins);
    chk({t, "_req"}, 32'(imem_req), 32'(rq));
    chk({t, "_addr"}, imem_addr, ad);
    chk({t, "_valid"}, 32'(valid_id), 32'(v));
    chk({t, "_pc"}, pc_id, pc);
    chk({t, "_instr"}, instr_id, ins);
  endtask

  typedef struct {
    bit          st;
    bit          jb;
    bit          ak;
    logic        rq;
    logic [31:0] ad;
    logic        v;
    logic [31:0] pc;
    logic [31:0] ins;
  } vec_t;

  function automatic vec_t mk(bit st, bit jb, bit ak, logic rq,
                              logic [31:0] ad, logic v,
                              logic [31:0] pc,
                              logic [31:0] ins);
    vec_t r;
    r.st = st; r.jb = jb; r.ak = ak; r.rq = rq;
    r.ad = ad; r.v = v; r.pc = pc; r.ins = ins;
    return r;
  endfunction

  vec_t        tbl [17];
  logic [31:0] prog [$];
  bit          has_t [4096];
  logic [31:0] tgt [4096];

  initial begin
    int d;
    int cur;
    bit prev_acc;
    bit prev_req;
    bit prev_ack;
    logic [31:0] prev_addr;

    // row: stall, branch, ack | req, addr, valid, pc, instr
    tbl[0]  = mk(0, 0, 1, 0, 32'h100, 0, 32'h000, 32'h000);
    tbl[1]  = mk(0, 0, 1, 1, 32'h100, 0, 32'h000, 32'h000);
    tbl[2]  = mk(0, 0, 1, 1, 32'h104, 1, 32'h100, 32'h100);
    tbl[3]  = mk(0, 0, 0, 1, 32'h108, 1, 32'h104, 32'h104);
    tbl[4]  = mk(0, 0, 1, 1, 32'h108, 0, 32'h104, 32'h000);
    tbl[5]  = mk(1, 0, 1, 1, 32'h10C, 1, 32'h108, 32'h108);
    tbl[6]  = mk(1, 0, 1, 0, 32'h110, 1, 32'h108, 32'h108);
    tbl[7]  = mk(1, 0, 0, 0, 32'h110, 1, 32'h108, 32'h108);
    tbl[8]  = mk(0, 0, 0, 0, 32'h110, 1, 32'h108, 32'h108);
    tbl[9]  = mk(0, 0, 1, 1, 32'h110, 1, 32'h10C, 32'h10C);
    tbl[10] = mk(0, 0, 0, 1, 32'h114, 1, 32'h110, 32'h110);
    tbl[11] = mk(1, 0, 1, 1, 32'h114, 0, 32'h110, 32'h000);
    tbl[12] = mk(1, 1, 0, 1, 32'h118, 1, 32'h114, 32'h114);
    tbl[13] = mk(0, 1, 0, 1, 32'h118, 1, 32'h114, 32'h114);
    tbl[14] = mk(0, 1, 1, 1, 32'h118, 0, 32'h114, 32'h000);
    tbl[15] = mk(0, 0, 1, 1, 32'h568, 1, 32'h118, 32'h118);
    tbl[16] = mk(0, 0, 0, 1, 32'h56C, 1, 32'h568, 32'h568);

    step();
    step();
    chk_out("reset", 0, RPC, 0, 32'h0, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      chk_out($sformatf("tbl%0d", i), tbl[i].rq, tbl[i].ad,
              tbl[i].v, tbl[i].pc, tbl[i].ins);
      drive(tbl[i].st, tbl[i].jb, 0, 0, 32'h0, tbl[i].ak);
      step();
    end

    // asynchronous reset while a fetch is outstanding
    drive(0, 0, 0, 0, 32'h0, 0);
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst", 0, RPC, 0, 32'h0, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    chk_out("restart0", 0, RPC, 0, 32'h0, 32'h0);
    step();
    chk_out("restart1", 1, RPC, 0, 32'h0, 32'h0);

    // JR, branch with slow memory, J, JR out of HOLD
    drive(0, 0, 0, 0, 32'h0, 1); step();
    chk("d_pc100", pc_id, 32'h100);
    chk("d_addr104", imem_addr, 32'h104);
    drive(0, 0, 0, 1, 32'h200, 1); step();
    chk("d_jr_addr", imem_addr, 32'h200);
    chk("d_jr_slot", pc_id, 32'h104);
    drive(0, 0, 0, 0, 32'h0, 0); step();
    drive(0, 0, 0, 0, 32'h0, 0); step();
    drive(0, 0, 0, 0, 32'h0, 1); step();
    chk("d_br_pc", pc_id, 32'h200);
    chk("d_br_instr", instr_id, 32'h1000_FFFE);
    chk("d_br_out", imem_addr, 32'h204);
    drive(1'b0, 1'b1, 0, 0, 32'h0, 0); step();
    chk("d_br_bubble", 32'(valid_id), 32'h0);
    chk("d_br_still", imem_addr, 32'h204);
    drive(0, 0, 0, 0, 32'h0, 0); step();
    drive(0, 0, 0, 0, 32'h0, 1); step();
    chk("d_br_slot_pc", pc_id, 32'h204);
    chk("d_br_slot_v", 32'(valid_id), 32'h1);
    chk("d_br_target", imem_addr, 32'h1FC);
    drive(0, 0, 0, 0, 32'h0, 1); step();
    chk("d_pc1fc", pc_id, 32'h1FC);
    drive(0, 0, 0, 1, 32'h3000_0010, 1); step();
    chk("d_jr2_addr", imem_addr, 32'h3000_0010);
    drive(0, 0, 0, 0, 32'h0, 1); step();
    chk("d_j_pc", pc_id, 32'h3000_0010);
    chk("d_j_instr", instr_id, 32'h0800_0040);
    chk("d_j_slot", imem_addr, 32'h3000_0014);
    drive(0, 0, 1, 0, 32'h0, 1); step();
    chk("d_j_target", imem_addr, 32'h3000_0100);
    chk("d_j_slot_pc", pc_id, 32'h3000_0014);
    drive(0, 0, 0, 0, 32'h0, 1); step();
    chk("d_pc_jr", pc_id, 32'h3000_0100);
    drive(1, 0, 0, 1, 32'h1111_0000, 1); step();
    chk("d_hold_req", 32'(imem_req), 32'h0);
    chk("d_hold_pc", pc_id, 32'h3000_0100);
    drive(1, 0, 0, 1, 32'h2222_0000, 0); step();
    chk("d_hold_req2", 32'(imem_req), 32'h0);
    chk("d_hold_pc2", pc_id, 32'h3000_0100);
    drive(0, 0, 0, 1, 32'hDEAD_BEE0, 0); step();
    chk("d_rel_req", 32'(imem_req), 32'h1);
    chk("d_rel_pc", pc_id, 32'h3000_0104);
    chk("d_jr3_addr", imem_addr, 32'hDEAD_BEE0);

    // randomized run checked against program order
    drive(0, 0, 0, 0, 32'h0, 0);
    rst_n = 1'b0;
    step();
    hash_mode = 1'b1;
    rst_n = 1'b1;
    d = 0;
    cur = -1;
    prev_acc = 1'b1;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    prev_addr = '0;
    for (int c = 0; c < 2000; c++) begin
      bit st, jb, jt, jr, ak;
      logic [31:0] jp;
      if (valid_id) begin
        if (prev_acc) begin
          if (d >= prog.size()) begin
            checks++;
            errs++;
            $display("FAIL rnd_unfetched: got instr %h expected none",
                     instr_id);
          end else begin
            cur = d;
            d++;
          end
        end
        if (cur >= 0) begin
          chk("rnd_pc", pc_id, prog[cur]);
          chk("rnd_instr", instr_id, hash(prog[cur]));
        end
      end else begin
        chk("rnd_nop", instr_id, 32'h0);
      end
      if (prev_req && !prev_ack && imem_req)
        chk("rnd_addr_stable", imem_addr, prev_addr);

      st = ($urandom_range(0, 9) < 3);
      jb = 1'($urandom_range(0, 1));
      jt = 1'($urandom_range(0, 1));
      jr = 1'($urandom_range(0, 1));
      jp = $urandom() & 32'hFFFF_FFFC;
      if (valid_id && !st) begin
        if (cur >= 0 && !(cur >= 1 && has_t[cur-1]) &&
            $urandom_range(0, 2) == 0) begin
          logic [31:0] p, ins, p4, t;
          int k;
          p = prog[cur];
          ins = hash(p);
          p4 = p + 32'd4;
          k = $urandom_range(0, 2);
          if (k == 0) begin
            jr = 1'b1;
            t = jp;
          end else if (k == 1) begin
            jr = 1'b0;
            jt = 1'b1;
            t = {p4[31:28], ins[25:0], 2'b00};
          end else begin
            jr = 1'b0;
            jt = 1'b0;
            jb = 1'b1;
            t = p4 + {{14{ins[15]}}, ins[15:0], 2'b00};
          end
          has_t[cur] = 1'b1;
          tgt[cur] = t;
        end else begin
          jb = 1'b0;
          jt = 1'b0;
          jr = 1'b0;
        end
      end
      ak = 1'($urandom_range(0, 1));
      if (ak && imem_req) begin
        int j;
        logic [31:0] e;
        j = prog.size();
        if (j == 0) e = RPC;
        else if (j >= 2 && has_t[j-2]) e = tgt[j-2];
        else e = prog[j-1] + 32'd4;
        chk("rnd_fetch_addr", imem_addr, e);
        prog.push_back(e);
      end
      drive(st, jb, jt, jr, jp, ak);
      prev_acc = !st || !valid_id;
      prev_req = imem_req;
      prev_ack = ak && imem_req;
      prev_addr = imem_addr;
      step();
    end
    chk("rnd_progress", 32'(d > 200), 32'h1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
